// File: rtl/xgmii_tx_ifc_pp.sv
// Purpose : 64-bit framed words to an XGMII TX column pair. Adds /S/+preamble+SFD, places /T/,
//           enforces a minimum inter-frame gap and reports underruns.
// Latency : SOF accepted on edge N -> preamble out on N; data word j out on edge N+1+j.
// Backpres: TxRdy drops while the EOF word waits in hold and for the whole IFG countdown.
//
// Ports   : Clk, Reset (sync, active high)
//           Txdv/Txd/TxSof/TxEof/TxMod/TxErr -> TxRdy   framed input, byte0 in Txd[63:56]
//           xgmii_txd/xgmii_txc                         registered XGMII column, lane n = [8n+7:8n]
//           TxUnderrun                                  one-cycle pulse when the frame runs dry
// Option  : define XGMII_TX_STAT_EN to add TxFrameCnt[31:0] and TxUnderrunCnt[15:0].

`ifndef XGMII_CHAR_S
`define XGMII_CHAR_S 8'hFB
`endif
`ifndef XGMII_CHAR_T
`define XGMII_CHAR_T 8'hFD
`endif

module xgmii_tx_ifc_pp #(
   parameter int IFG_BYTES = 12
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Txdv,
   input  logic [63:0] Txd,
   input  logic        TxSof,
   input  logic        TxEof,
   input  logic [2:0]  TxMod,
   input  logic        TxErr,
   output logic        TxRdy,
   output logic [63:0] xgmii_txd,
   output logic [7:0]  xgmii_txc,
   output logic        TxUnderrun
`ifdef XGMII_TX_STAT_EN
   ,
   output logic [31:0] TxFrameCnt,
   output logic [15:0] TxUnderrunCnt
`endif
);

   localparam logic [7:0]  CH_I = 8'h07;
   localparam logic [7:0]  CH_S = `XGMII_CHAR_S;
   localparam logic [7:0]  CH_T = `XGMII_CHAR_T;
   localparam logic [7:0]  CH_E = 8'hFE;

   localparam logic [63:0] IDLE_COL = {8{CH_I}};
   // Lane 0 carries /S/, lanes 1-6 preamble, lane 7 SFD.
   localparam logic [63:0] PRE_COL  = {8'hD5, {6{8'h55}}, CH_S};
   localparam logic [63:0] TERM_COL = {{7{CH_I}}, CH_T};
   localparam logic [63:0] UND_COL  = {{6{CH_I}}, CH_T, CH_E};

   // Idle columns needed to cover r remaining gap bytes.
   function automatic logic [3:0] idle_words(input int r);
      if (r <= 0) return 4'd0;
      return 4'((r + 7) / 8);
   endfunction

   // Gap already covered by the terminate column: 8 bytes for a /T/-only column, 7 after underrun.
   localparam logic [3:0] TERM_WORDS = idle_words(IFG_BYTES - 8);
   localparam logic [3:0] UND_WORDS  = idle_words(IFG_BYTES - 7);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_TERM,
      ST_IFG,
      ST_DROP
   } state_t;

   state_t      state;
   logic [63:0] hold;
   logic        hold_vld;
   logic        hold_eof;
   logic [2:0]  hold_mod;
   logic        hold_err;
   logic [3:0]  ifg_cnt;

   logic [63:0] data_col;
   logic [63:0] eof_txd;
   logic [7:0]  eof_txc;
   logic [3:0]  eof_words;

   assign TxRdy = !Reset && ((state == ST_IDLE) || (state == ST_DROP) ||
                             (state == ST_DATA && !hold_eof));

   // Wire byte b sits at Txd[63-8b -: 8] but belongs on lane b.
   always_comb begin
      data_col = '0;
      for (int i = 0; i < 8; i++) begin
         data_col[8*i +: 8] = hold[63-8*i -: 8];
      end
   end

   // EOF column: hold_mod data lanes (all 8 when 0), then /T/, then idle fill.
   always_comb begin
      eof_txd = '0;
      eof_txc = '0;
      for (int i = 0; i < 8; i++) begin
         if (hold_mod == 3'd0 || i < int'(hold_mod)) begin
            eof_txd[8*i +: 8] = hold_err ? CH_E : hold[63-8*i -: 8];
            eof_txc[i]        = hold_err;
         end else if (i == int'(hold_mod)) begin
            eof_txd[8*i +: 8] = CH_T;
            eof_txc[i]        = 1'b1;
         end else begin
            eof_txd[8*i +: 8] = CH_I;
            eof_txc[i]        = 1'b1;
         end
      end
   end

   // /T/ in lane k leaves 8-k gap bytes in the EOF column.
   assign eof_words = idle_words(IFG_BYTES - 8 + int'(hold_mod));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= ST_IDLE;
         hold       <= '0;
         hold_vld   <= 1'b0;
         hold_eof   <= 1'b0;
         hold_mod   <= '0;
         hold_err   <= 1'b0;
         ifg_cnt    <= '0;
         xgmii_txd  <= IDLE_COL;
         xgmii_txc  <= 8'hFF;
         TxUnderrun <= 1'b0;
      end else begin
         xgmii_txd  <= IDLE_COL;
         xgmii_txc  <= 8'hFF;
         TxUnderrun <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Words without SOF are dropped here.
               if (Txdv && TxSof) begin
                  xgmii_txd <= PRE_COL;
                  xgmii_txc <= 8'h01;
                  hold      <= Txd;
                  hold_vld  <= 1'b1;
                  hold_eof  <= TxEof;
                  hold_mod  <= TxMod;
                  hold_err  <= TxErr && TxEof;
                  state     <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (!hold_vld) begin
                  xgmii_txd  <= UND_COL;
                  xgmii_txc  <= 8'hFF;
                  TxUnderrun <= 1'b1;
                  // The word accepted on this edge may already be the EOF.
                  if (Txdv && TxEof) begin
                     ifg_cnt <= UND_WORDS;
                     state   <= (UND_WORDS == 4'd0) ? ST_IDLE : ST_IFG;
                  end else begin
                     state <= ST_DROP;
                  end
               end else if (!hold_eof) begin
                  xgmii_txd <= data_col;
                  xgmii_txc <= 8'h00;
                  hold      <= Txd;
                  hold_vld  <= Txdv;
                  hold_eof  <= Txdv && TxEof;
                  hold_mod  <= TxMod;
                  hold_err  <= Txdv && TxEof && TxErr;
               end else begin
                  xgmii_txd <= eof_txd;
                  xgmii_txc <= eof_txc;
                  hold_vld  <= 1'b0;
                  hold_eof  <= 1'b0;
                  if (hold_mod == 3'd0) begin
                     state <= ST_TERM;
                  end else begin
                     ifg_cnt <= eof_words;
                     state   <= (eof_words == 4'd0) ? ST_IDLE : ST_IFG;
                  end
               end
            end
            ST_TERM: begin
               xgmii_txd <= TERM_COL;
               xgmii_txc <= 8'hFF;
               ifg_cnt   <= TERM_WORDS;
               state     <= (TERM_WORDS == 4'd0) ? ST_IDLE : ST_IFG;
            end
            ST_IFG: begin
               if (ifg_cnt <= 4'd1) state <= ST_IDLE;
               else                 ifg_cnt <= ifg_cnt - 4'd1;
            end
            ST_DROP: begin
               if (Txdv && TxEof) begin
                  ifg_cnt <= UND_WORDS;
                  state   <= (UND_WORDS == 4'd0) ? ST_IDLE : ST_IFG;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef XGMII_TX_STAT_EN
   logic t_evt;
   logic u_evt;

   // Normal /T/ is either in the EOF column (k!=0) or in the terminate-only column.
   assign t_evt = (state == ST_TERM) ||
                  (state == ST_DATA && hold_vld && hold_eof && hold_mod != 3'd0);
   assign u_evt = (state == ST_DATA) && !hold_vld;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         TxFrameCnt    <= '0;
         TxUnderrunCnt <= '0;
      end else begin
         if (t_evt) TxFrameCnt <= TxFrameCnt + 32'd1;
         if (u_evt && TxUnderrunCnt != 16'hFFFF) TxUnderrunCnt <= TxUnderrunCnt + 16'd1;
      end
   end
`endif

endmodule
